// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter: state encodings and
// default data-path widths.
package ysyx_22040759_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_CNT_W  = 32;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_REQ_MEM  = 3'd1,
    ARB_WAIT_MEM = 3'd2,
    ARB_REQ_IF   = 3'd3,
    ARB_WAIT_IF  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Shares one downstream memory port between instruction fetch and the MEM stage.
// One transaction in flight; MEM has fixed priority; a branch flush drops a fetch response.
//
// state        | meaning
// ARB_IDLE     | no transaction; grants issued combinationally here
// ARB_REQ_MEM  | bus_req held with latched load/store payload until bus_gnt
// ARB_WAIT_MEM | waiting for the load data / store ack
// ARB_REQ_IF   | bus_req held with latched fetch address until bus_gnt
// ARB_WAIT_IF  | waiting for fetch data
module ysyx_22040759_mem_arbiter
  import ysyx_22040759_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int STRB_W = DATA_W / 8,
  parameter int CNT_W  = ARB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  arb_conflict_cnt
);

  arb_state_e state, state_next;
  logic grant_mem, grant_if;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic drop_q;
  logic if_rvalid_q, mem_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic [CNT_W-1:0] conflict_q;
  logic in_if, mem_done, if_done;

  always_ff @(posedge clk) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_next;
  end

  // Grants are suppressed while reset is asserted: the state is about to be discarded.
  always_comb begin
    state_next = state;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (rst && mem_req) begin
          grant_mem  = 1'b1;
          state_next = ARB_REQ_MEM;
        end else if (rst && if_req) begin
          grant_if   = 1'b1;
          state_next = ARB_REQ_IF;
        end
      end
      ARB_REQ_MEM:  if (bus_gnt)    state_next = ARB_WAIT_MEM;
      ARB_WAIT_MEM: if (bus_rvalid) state_next = ARB_IDLE;
      ARB_REQ_IF:   if (bus_gnt)    state_next = ARB_WAIT_IF;
      ARB_WAIT_IF:  if (bus_rvalid) state_next = ARB_IDLE;
      default:      state_next = ARB_IDLE;
    endcase
  end

  assign in_if    = (state == ARB_REQ_IF) || (state == ARB_WAIT_IF);
  assign mem_done = (state == ARB_WAIT_MEM) && bus_rvalid;
  assign if_done  = (state == ARB_WAIT_IF) && bus_rvalid && !(drop_q || if_flush);

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (grant_mem) begin
      we_q    <= mem_we;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_we ? mem_wstrb : '0;
    end else if (grant_if) begin
      we_q    <= 1'b0;
      addr_q  <= if_addr;
      wdata_q <= '0;
      wstrb_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                       drop_q <= 1'b0;
    else if (grant_if)              drop_q <= if_flush;
    else if (state_next == ARB_IDLE) drop_q <= 1'b0;
    else if (in_if && if_flush)     drop_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      conflict_q   <= '0;
    end else begin
      if_rvalid_q  <= if_done;
      mem_rvalid_q <= mem_done;
      if (if_done)  if_rdata_q  <= bus_rdata;
      if (mem_done) mem_rdata_q <= we_q ? '0 : bus_rdata;
      if (state == ARB_IDLE && if_req && mem_req && conflict_q != '1)
        conflict_q <= conflict_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign if_gnt           = grant_if;
  assign mem_gnt          = grant_mem;
  assign if_rvalid        = if_rvalid_q;
  assign if_rdata         = if_rdata_q;
  assign mem_rvalid       = mem_rvalid_q;
  assign mem_rdata        = mem_rdata_q;
  assign bus_req          = (state == ARB_REQ_MEM) || (state == ARB_REQ_IF);
  assign bus_we           = we_q;
  assign bus_addr         = addr_q;
  assign bus_wdata        = wdata_q;
  assign bus_wstrb        = wstrb_q;
  assign busy             = (state != ARB_IDLE);
  assign arb_conflict_cnt = conflict_q;

endmodule
